regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 24 ++
 rtl/wb_slot.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 126 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, source encoding and slot record for the register-file writeback path.
// Rev 1.0
`default_nettype none

package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef struct packed {
    logic              full;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;

endpackage

`default_nettype wire

// File: rtl/wb_slot.sv
// wb_slot: one-entry writeback holding buffer with valid/ready intake and grant-driven drain.
// Rev 1.0
`default_nettype none

module wb_slot
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output slot_t             slot
);

  // A granted slot drains this edge, so it can take a new entry in the same cycle.
  assign ready = !slot.full || grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (valid && ready && (addr != '0)) begin
      slot.full <= 1'b1;
      slot.addr <= addr;
      slot.data <= data;
    end else if (grant) begin
      // Writes to register 0 are swallowed here and never occupy the slot.
      slot.full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register-file write port between ALU and load
// writeback, plus the per-register busy scoreboard used by issue. Rev 1.0
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] chk_addr_A,
  input  logic [ADDR_W-1:0] chk_addr_B,
  input  logic [ADDR_W-1:0] chk_addr_D,
  output logic              busy_A,
  output logic              busy_B,
  output logic              busy_D,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data
);

  import regfile_pkg::src_e;
  import regfile_pkg::slot_t;
  import regfile_pkg::SRC_ALU;
  import regfile_pkg::SRC_MEM;

  slot_t            a_slot;
  slot_t            m_slot;
  logic             a_grant;
  logic             m_grant;
  src_e             ptr;
  src_e             ptr_next;
  logic [NREG-1:0]  busy;

  wb_slot u_slot_a (
    .clk   (clk),
    .rst   (rst),
    .valid (a_valid),
    .ready (a_ready),
    .addr  (a_addr),
    .data  (a_data),
    .grant (a_grant),
    .slot  (a_slot)
  );

  wb_slot u_slot_m (
    .clk   (clk),
    .rst   (rst),
    .valid (m_valid),
    .ready (m_ready),
    .addr  (m_addr),
    .data  (m_data),
    .grant (m_grant),
    .slot  (m_slot)
  );

  always_comb begin
    a_grant = a_slot.full && (!m_slot.full || (ptr == SRC_ALU));
    m_grant = m_slot.full && (!a_slot.full || (ptr == SRC_MEM));
  end

  // Pointer always names the source that lost (or did not ask) on the last grant.
  always_comb begin
    ptr_next = ptr;
    if (a_grant) begin
      ptr_next = SRC_MEM;
    end else if (m_grant) begin
      ptr_next = SRC_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= SRC_ALU;
    end else begin
      ptr <= ptr_next;
    end
  end

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (a_grant) begin
      rf_we   = 1'b1;
      rf_addr = a_slot.addr;
      rf_data = a_slot.data;
    end else if (m_grant) begin
      rf_we   = 1'b1;
      rf_addr = m_slot.addr;
      rf_data = m_slot.data;
    end
  end

  // Later non-blocking set overrides the clear, so a fresh reservation beats a same-cycle commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (rf_we) begin
        busy[rf_addr] <= 1'b0;
      end
      if (rsv_valid && (rsv_addr != '0)) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  assign busy_A = (chk_addr_A != '0) && busy[chk_addr_A];
  assign busy_B = (chk_addr_B != '0) && busy[chk_addr_B];
  assign busy_D = (chk_addr_D != '0) && busy[chk_addr_D];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for the writeback arbiter and scoreboard.
// Rev 1.0
`default_nettype none

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, m_valid, rsv_valid;
  logic        a_ready, m_ready;
  logic [4:0]  a_addr, m_addr, rsv_addr;
  logic [31:0] a_data, m_data;
  logic [4:0]  chk_addr_A, chk_addr_B, chk_addr_D;
  logic        busy_A, busy_B, busy_D;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_cmp;
  int n_fail;
  logic [31:0] model_busy;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .chk_addr_A (chk_addr_A),
    .chk_addr_B (chk_addr_B),
    .chk_addr_D (chk_addr_D),
    .busy_A     (busy_A),
    .busy_B     (busy_B),
    .busy_D     (busy_D),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: no reservation of a still-pending register, no unreserved writeback.
  always @(posedge rst) model_busy = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we) begin
        n_cmp++;
        if (model_busy[rf_addr] !== 1'b1) begin
          n_fail++;
          $display("FAIL proto_wb_unreserved: wrote reg %0d, reserved flag %0b required 1", rf_addr, model_busy[rf_addr]);
        end
        model_busy[rf_addr] = 1'b0;
      end
      if (rsv_valid && rsv_addr != 5'd0) begin
        n_cmp++;
        if (model_busy[rsv_addr] !== 1'b0) begin
          n_fail++;
          $display("FAIL proto_waw: reserve reg %0d while pending, flag %0b required 0", rsv_addr, model_busy[rsv_addr]);
        end
        model_busy[rsv_addr] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid   = 1'b0;
    m_valid   = 1'b0;
    rsv_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    a_addr = '0; a_data = '0; m_addr = '0; m_data = '0; rsv_addr = '0;
    chk_addr_A = 5'd0; chk_addr_B = 5'd0; chk_addr_D = 5'd0;
    #2;
    n_cmp++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0) begin n_fail++;
      $display("FAIL reset_wport: got we=%0b addr=%0d data=%h required 0/0/0", rf_we, rf_addr, rf_data); end
    #10;
    rst = 1'b0;
    tick();
    n_cmp++; if (a_ready !== 1'b1 || m_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got a=%0b m=%0b required 1/1", a_ready, m_ready); end
    n_cmp++; if (busy_A !== 1'b0 || busy_B !== 1'b0 || busy_D !== 1'b0 || rf_we !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got A=%0b B=%0b D=%0b we=%0b required 0", busy_A, busy_B, busy_D, rf_we); end
  endtask

  task automatic test_reset_midop();
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    tick();
    rsv_addr = 5'd6;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h5555;
    m_valid = 1'b1; m_addr = 5'd6; m_data = 32'h6666;
    tick();
    idle();
    chk_addr_A = 5'd5; chk_addr_B = 5'd6;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || busy_A !== 1'b1) begin n_fail++;
      $display("FAIL midop_prefill: got we=%0b addr=%0d busyA=%0b required 1/5/1", rf_we, rf_addr, busy_A); end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    n_cmp++; if (rf_we !== 1'b0 || a_ready !== 1'b1 || m_ready !== 1'b1) begin n_fail++;
      $display("FAIL midop_slots: got we=%0b a_ready=%0b m_ready=%0b required 0/1/1", rf_we, a_ready, m_ready); end
    n_cmp++; if (busy_A !== 1'b0 || busy_B !== 1'b0) begin n_fail++;
      $display("FAIL midop_busy: got A=%0b B=%0b required 0/0", busy_A, busy_B); end
  endtask

  task automatic test_concurrent();
    chk_addr_A = 5'd3; chk_addr_B = 5'd7;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd7;
    tick();
    rsv_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h0000_00A3;
    m_valid = 1'b1; m_addr = 5'd7; m_data = 32'h0000_0077;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || m_ready !== 1'b1 || rf_we !== 1'b0 || busy_A !== 1'b1 || busy_B !== 1'b1) begin n_fail++;
      $display("FAIL conc_accept: got a_rdy=%0b m_rdy=%0b we=%0b bA=%0b bB=%0b required 1/1/0/1/1", a_ready, m_ready, rf_we, busy_A, busy_B); end
    tick();
    idle();
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h0000_00A3) begin n_fail++;
      $display("FAIL conc_first: got we=%0b addr=%0d data=%h required 1/3/000000a3", rf_we, rf_addr, rf_data); end
    n_cmp++; if (a_ready !== 1'b1 || m_ready !== 1'b0) begin n_fail++;
      $display("FAIL conc_ready1: got a=%0b m=%0b required 1/0", a_ready, m_ready); end
    tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'h0000_0077) begin n_fail++;
      $display("FAIL conc_second: got we=%0b addr=%0d data=%h required 1/7/00000077", rf_we, rf_addr, rf_data); end
    n_cmp++; if (a_ready !== 1'b1 || m_ready !== 1'b1 || busy_A !== 1'b0 || busy_B !== 1'b1) begin n_fail++;
      $display("FAIL conc_ready2: got a=%0b m=%0b bA=%0b bB=%0b required 1/1/0/1", a_ready, m_ready, busy_A, busy_B); end
    tick();
    n_cmp++; if (rf_we !== 1'b0 || busy_B !== 1'b0) begin n_fail++;
      $display("FAIL conc_drain: got we=%0b bB=%0b required 0/0", rf_we, busy_B); end
  endtask

  task automatic test_single_write();
    chk_addr_D = 5'd5;
    rsv_valid = 1'b1; rsv_addr = 5'd5;
    tick();
    rsv_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_1234;
    #1;
    n_cmp++; if (a_ready !== 1'b1 || busy_D !== 1'b1 || rf_we !== 1'b0) begin n_fail++;
      $display("FAIL single_accept: got rdy=%0b busyD=%0b we=%0b required 1/1/0", a_ready, busy_D, rf_we); end
    tick();
    idle();
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'h0000_1234) begin n_fail++;
      $display("FAIL single_write: got we=%0b addr=%0d data=%h required 1/5/00001234", rf_we, rf_addr, rf_data); end
    n_cmp++; if (busy_D !== 1'b1) begin n_fail++;
      $display("FAIL single_busy_hold: got %0b required 1", busy_D); end
    tick();
    n_cmp++; if (busy_D !== 1'b0 || rf_we !== 1'b0) begin n_fail++;
      $display("FAIL single_busy_clear: got busyD=%0b we=%0b required 0/0", busy_D, rf_we); end
  endtask

  task automatic test_back_to_back();
    int ai, mi, wi, cyc;
    logic af, mf;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    ai = 0; mi = 0; wi = 0;
    for (int k = 0; k < 8; k++) begin
      rsv_valid = 1'b1; rsv_addr = 5'(10 + k);
      tick();
      rsv_addr = 5'(20 + k);
      tick();
    end
    rsv_valid = 1'b0;
    // Pointer points at M here (last grant was A), so the write order is M0, A0, M1, A1, ...
    for (cyc = 0; cyc < 40 && wi < 16; cyc++) begin
      a_valid = (ai < 8); a_addr = 5'(10 + ai); a_data = 32'hA000_0000 + 32'(ai);
      m_valid = (mi < 8); m_addr = 5'(20 + mi); m_data = 32'hB000_0000 + 32'(mi);
      #1;
      af = a_valid && a_ready;
      mf = m_valid && m_ready;
      if (cyc >= 1) begin
        exp_addr = (wi % 2 == 0) ? 5'(20 + wi / 2) : 5'(10 + wi / 2);
        exp_data = ((wi % 2 == 0) ? 32'hB000_0000 : 32'hA000_0000) + 32'(wi / 2);
        n_cmp++; if (rf_we !== 1'b1 || rf_addr !== exp_addr || rf_data !== exp_data) begin n_fail++;
          $display("FAIL b2b_write%0d: got we=%0b addr=%0d data=%h required 1/%0d/%h", wi, rf_we, rf_addr, rf_data, exp_addr, exp_data); end
        wi++;
      end
      tick();
      if (af) ai++;
      if (mf) mi++;
    end
    idle();
    n_cmp++; if (wi != 16 || ai != 8 || mi != 8) begin n_fail++;
      $display("FAIL b2b_count: got writes=%0d a=%0d m=%0d required 16/8/8", wi, ai, mi); end
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle: got we=%0b required 0", rf_we); end
  endtask

  task automatic test_addr_zero();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_fail++;
      $display("FAIL zero_ready: got %0b required 1", a_ready); end
    tick();
    idle();
    #1;
    n_cmp++; if (rf_we !== 1'b0 || a_ready !== 1'b1) begin n_fail++;
      $display("FAIL zero_dropped: got we=%0b rdy=%0b required 0/1", rf_we, a_ready); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++;
      $display("FAIL zero_later: got we=%0b required 0", rf_we); end
  endtask

  task automatic test_rsv_collision();
    chk_addr_D = 5'd9; chk_addr_A = 5'd0;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0099;
    tick();
    a_valid = 1'b0;
    rsv_valid = 1'b1; rsv_addr = 5'd9;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'd9 || busy_D !== 1'b1 || busy_A !== 1'b0) begin n_fail++;
      $display("FAIL coll_commit: got we=%0b addr=%0d bD=%0b bA=%0b required 1/9/1/0", rf_we, rf_addr, busy_D, busy_A); end
    tick();
    rsv_valid = 1'b0;
    #1;
    n_cmp++; if (busy_D !== 1'b1) begin n_fail++;
      $display("FAIL coll_rsv_wins: got %0b required 1", busy_D); end
    tick();
    n_cmp++; if (busy_D !== 1'b1) begin n_fail++;
      $display("FAIL coll_hold: got %0b required 1", busy_D); end
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0999;
    tick();
    a_valid = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_data !== 32'h0000_0999 || busy_D !== 1'b1) begin n_fail++;
      $display("FAIL coll_second: got we=%0b data=%h bD=%0b required 1/00000999/1", rf_we, rf_data, busy_D); end
    tick();
    n_cmp++; if (busy_D !== 1'b0) begin n_fail++;
      $display("FAIL coll_clear: got %0b required 0", busy_D); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    model_busy = '0;
    test_reset();
    test_reset_midop();
    test_concurrent();
    test_single_write();
    test_back_to_back();
    test_addr_zero();
    test_rsv_collision();
    tick();
    n_cmp++; if (model_busy !== 32'd0) begin n_fail++;
      $display("FAIL proto_unwritten: got pending %h required 00000000", model_busy); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
